lcd_cmd_sequencer: RTL
======================

# lcd_cmd_sequencer

Controller that sequences the character-LCD bus and shares the 1 ms delay timer across every LCD wait. After `start`, it runs the power-on wait and the 6-command HD44780 initialisation, with a timed wait after each command. It then accepts single host byte writes through a req/ack handshake. It sits between the top-level user logic and the LCD pins, and drives the delay timer's `EnableCount`/`DisableCount` inputs while counting its `TimerIndicator` pulses.

## Interface
- `PWR_WAIT_TICKS`, default 15: timer ticks waited after `start` before the first command.
- `CMD_WAIT_TICKS`, default 2: ticks waited after every command or data write except clear.
- `CLR_WAIT_TICKS`, default 3: ticks waited after the clear command 0x01.
- `E_PULSE_CYCLES`, default 4: clock cycles `lcd_e` stays high per write.
- `clock` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin (or restart) the initialisation; sampled in IDLE or READY.
- `TimerIndicator` in 1: one-cycle tick pulse from the delay timer.
- `EnableCount` out 1: timer run request.
- `DisableCount` out 1: one-cycle timer clear.
- `wr_req` in 1: host write request, held until acknowledged.
- `wr_rs` in 1: register select for the host write (0 = command, 1 = data).
- `wr_data` in 8: host write byte.
- `wr_ack` out 1: one-cycle pulse; the host write has been captured.
- `lcd_rs`, `lcd_rw`, `lcd_e` out 1 each: LCD control pins; `lcd_rw` is always 0.
- `lcd_data` out 8: LCD data bus.
- `busy` out 1: high in every state except IDLE and READY.
- `done` out 1: initialisation complete; high only in READY.

## Operation
- States: IDLE, SETUP, EHIGH, ARM, COUNT, READY.
- Registers:
  - 3-bit `step` (init index 0–5; 6 = host write).
  - 8-bit tick counter and 8-bit target.
  - E-pulse counter.
  - Captured `rs`/`data`.
  - 1-bit `pwr` flag.
- Init ROM, with RS=0 for every entry:
  - 0: 0x38
  - 1: 0x38
  - 2: 0x38
  - 3: 0x0C
  - 4: 0x01, followed by the CLR_WAIT_TICKS wait
  - 5: 0x06
- IDLE: on `start`, set `pwr`=1 and target=PWR_WAIT_TICKS, then go to ARM.
- ARM (exactly 1 cycle):
  - `DisableCount`=1, `EnableCount`=0.
  - Tick counter is cleared.
  - Next state is COUNT.
- COUNT:
  - `EnableCount`=1.
  - Each `TimerIndicator` increments the tick counter.
  - The cycle the incremented value equals the target, go to the exit state; `EnableCount`=0 from that next cycle.
  - Exit state:
    - If `pwr`=1: clear `pwr`, set `step`=0, go to SETUP.
    - Else if `step`<5: increment `step`, go to SETUP.
    - Else if `step`=5 or `step`=6: go to READY.
- SETUP (1 cycle):
  - Drive `lcd_rs`/`lcd_data` from the ROM (steps 0–5) or from the captured host values (step 6).
  - `lcd_e`=0. Next state is EHIGH.
- EHIGH:
  - `lcd_e`=1 for E_PULSE_CYCLES cycles; `lcd_data` and `lcd_rs` are held.
  - Then `lcd_e`=0.
  - Set target to CLR_WAIT_TICKS if the byte is 0x01 with RS=0, else CMD_WAIT_TICKS, and go to ARM.
  - `lcd_data`/`lcd_rs` keep their values until the next SETUP.
- READY:
  - `done`=1.
  - `start` has priority over `wr_req`: `start` restarts the sequence as from IDLE and `done` falls.
  - Otherwise, `wr_req` pulses `wr_ack` for one cycle, captures `wr_rs`/`wr_data`, sets `step`=6, and goes to SETUP.
- A parameter value of 0 is treated as 1.
- The tick counter saturates and never wraps.

## Timing
- Reset values: state IDLE; all outputs 0, including `EnableCount`, `DisableCount`, `lcd_e`, `lcd_data`, `busy`, `done` and `wr_ack`.
- `rst` low at any point, including mid-pulse with `lcd_e`=1, forces the reset values asynchronously. The sequence does not resume.
- `TimerIndicator` is ignored outside COUNT, including during the ARM cycle.
- `start` is ignored while `busy`=1.
- `wr_req` is ignored (no ack) outside READY; the request stays pending until READY is reached.
- `wr_req` and `start` asserted in the same READY cycle: `start` wins and no ack is issued.
- Data setup: `lcd_data` is stable 1 cycle before `lcd_e` rises and stays stable after it falls.
- Latency from a `wr_ack` to the `lcd_e` rise is 2 cycles.

## Test plan
- Parameters PWR=3, CMD=1, CLR=2, E=2, with a timer model ticking every 10 cycles while enabled. Pulse `start` -> `lcd_data` shows exactly 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0 and six 2-cycle `lcd_e` pulses. `DisableCount` pulses once before each of the 7 waits. The wait after 0x01 spans 2 ticks. `done`=1 afterwards.
- In READY, drive `wr_req`=1, `wr_rs`=1, `wr_data`=0x41 -> `wr_ack` pulses 1 cycle; `lcd_rs`=1 and `lcd_data`=0x41 one cycle before `lcd_e` rises; `busy` falls after 1 tick.
- Hold `wr_req` during init -> no `wr_ack` until `done`=1, then exactly one ack.
- Inject `TimerIndicator` pulses during SETUP, EHIGH and ARM -> the tick count is unaffected and the wait length is unchanged.
- Assert `rst`=0 during the third `lcd_e` pulse -> `lcd_e`, `EnableCount` and `busy` drop to 0 immediately (before the next clock edge). After release the block stays in IDLE until `start`.
- `start` and `wr_req` in the same READY cycle -> init reruns, `done`=0, and no `wr_ack`.

Source files
------------

// File: rtl/lcd_cmd_sequencer_if.sv
// Host write handshake and LCD pin bundle for lcd_cmd_sequencer.
interface lcd_cmd_sequencer_if;
    logic       wr_req;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    // Host side: issues writes and observes the LCD pins
    modport master (
        output wr_req, wr_rs, wr_data,
        input  wr_ack, lcd_rs, lcd_rw, lcd_e, lcd_data
    );

    // Sequencer side
    modport slave (
        input  wr_req, wr_rs, wr_data,
        output wr_ack, lcd_rs, lcd_rw, lcd_e, lcd_data
    );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 character-LCD sequencer: power-on wait, 6-command init, then single
// host byte writes, with every wait timed by counting external 1 ms timer ticks.
module lcd_cmd_sequencer #(
    parameter int unsigned PWR_WAIT_TICKS = 15,
    parameter int unsigned CMD_WAIT_TICKS = 2,
    parameter int unsigned CLR_WAIT_TICKS = 3,
    parameter int unsigned E_PULSE_CYCLES = 4
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                start,
    input  logic                TimerIndicator,
    output logic                EnableCount,
    output logic                DisableCount,
    output logic                busy,
    output logic                done,
    lcd_cmd_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned DATA_W = 8;

    // Zero is treated as one; values beyond the 8-bit counters are capped.
    function automatic int unsigned clamp_cfg(input int unsigned v);
        if (v == 0) begin
            return 1;
        end else if (v > 255) begin
            return 255;
        end else begin
            return v;
        end
    endfunction

    localparam logic [CNT_W-1:0]  PWR_T  = CNT_W'(clamp_cfg(PWR_WAIT_TICKS));
    localparam logic [CNT_W-1:0]  CMD_T  = CNT_W'(clamp_cfg(CMD_WAIT_TICKS));
    localparam logic [CNT_W-1:0]  CLR_T  = CNT_W'(clamp_cfg(CLR_WAIT_TICKS));
    localparam logic [CNT_W-1:0]  E_LAST = CNT_W'(clamp_cfg(E_PULSE_CYCLES) - 1);
    localparam logic [STEP_W-1:0] STEP_LAST_INIT = STEP_W'(5);
    localparam logic [STEP_W-1:0] STEP_HOST      = STEP_W'(6);
    localparam logic [DATA_W-1:0] CLEAR_CMD      = DATA_W'(8'h01);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_ARM,
        S_COUNT,
        S_READY
    } state_t;

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   ecnt_q, ecnt_d;
    logic               cap_rs_q, cap_rs_d;
    logic [DATA_W-1:0]  cap_data_q, cap_data_d;
    logic               pwr_q, pwr_d;
    logic               lcd_rs_q, lcd_rs_d;
    logic [DATA_W-1:0]  lcd_data_q, lcd_data_d;
    logic               en_q, dis_q, lcd_e_q, busy_q, done_q;
    logic [CNT_W-1:0]   tick_inc;
    logic               wr_ack_c;

    // Init command ROM; every entry is a command (RS=0)
    function automatic logic [DATA_W-1:0] rom_byte(input logic [STEP_W-1:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            3'd5:             return 8'h06;
            default:          return 8'h00;
        endcase
    endfunction

    // Next-state, datapath updates and the values the output registers take
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        tick_d     = tick_q;
        target_d   = target_q;
        ecnt_d     = ecnt_q;
        cap_rs_d   = cap_rs_q;
        cap_data_d = cap_data_q;
        pwr_d      = pwr_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        wr_ack_c   = 1'b0;
        tick_inc   = (tick_q == {CNT_W{1'b1}}) ? tick_q : tick_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pwr_d    = 1'b1;
                    target_d = PWR_T;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                tick_d  = '0;
                state_d = S_COUNT;
            end
            S_COUNT: begin
                if (TimerIndicator) begin
                    tick_d = tick_inc;
                    if (tick_inc == target_q) begin
                        if (pwr_q) begin
                            pwr_d   = 1'b0;
                            step_d  = '0;
                            state_d = S_SETUP;
                        end else if (step_q < STEP_LAST_INIT) begin
                            step_d  = step_q + STEP_W'(1);
                            state_d = S_SETUP;
                        end else begin
                            state_d = S_READY;
                        end
                    end
                end
            end
            S_SETUP: begin
                ecnt_d  = '0;
                state_d = S_EHIGH;
            end
            S_EHIGH: begin
                if (ecnt_q == E_LAST) begin
                    target_d = (lcd_data_q == CLEAR_CMD && !lcd_rs_q) ? CLR_T : CMD_T;
                    state_d  = S_ARM;
                end else begin
                    ecnt_d = ecnt_q + CNT_W'(1);
                end
            end
            S_READY: begin
                if (start) begin
                    pwr_d    = 1'b1;
                    target_d = PWR_T;
                    state_d  = S_ARM;
                end else if (bus.wr_req) begin
                    wr_ack_c   = 1'b1;
                    cap_rs_d   = bus.wr_rs;
                    cap_data_d = bus.wr_data;
                    step_d     = STEP_HOST;
                    state_d    = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus values are loaded on entry to SETUP so they lead lcd_e by a cycle
        if (state_d == S_SETUP) begin
            if (step_d == STEP_HOST) begin
                lcd_rs_d   = cap_rs_d;
                lcd_data_d = cap_data_d;
            end else begin
                lcd_rs_d   = 1'b0;
                lcd_data_d = rom_byte(step_d);
            end
        end
    end

    // State, datapath and output registers; outputs follow the next state
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            tick_q     <= '0;
            target_q   <= '0;
            ecnt_q     <= '0;
            cap_rs_q   <= 1'b0;
            cap_data_q <= '0;
            pwr_q      <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
            en_q       <= 1'b0;
            dis_q      <= 1'b0;
            lcd_e_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            tick_q     <= tick_d;
            target_q   <= target_d;
            ecnt_q     <= ecnt_d;
            cap_rs_q   <= cap_rs_d;
            cap_data_q <= cap_data_d;
            pwr_q      <= pwr_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            en_q       <= (state_d == S_COUNT);
            dis_q      <= (state_d == S_ARM);
            lcd_e_q    <= (state_d == S_EHIGH);
            busy_q     <= (state_d != S_IDLE) && (state_d != S_READY);
            done_q     <= (state_d == S_READY);
        end
    end

    // The ack is decoded in the capture cycle itself, two cycles ahead of lcd_e
    assign bus.wr_ack   = wr_ack_c;
    assign bus.lcd_rs   = lcd_rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_e    = lcd_e_q;
    assign bus.lcd_data = lcd_data_q;
    assign EnableCount  = en_q;
    assign DisableCount = dis_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
